reset_gen: RTL and testbench
============================

# reset_gen

Reset generator for the VGA frame-buffer design. It combines the external push-button reset and the clock-PLL lock indication into one global reset condition. It produces one active-high reset per clock domain: system (clk_sys) and pixel (pix_clk). Each output asserts immediately and releases cleanly on its own clock after a fixed synchronizer delay. The block sits at the top level, directly after the clock PLL, and feeds every downstream block's reset port.

## Interface
- Clocking/reset: one clock; reset is synchronous and active-high.
  - This applies per output domain: srst belongs only to clk_sys, prst belongs only to pix_clk.
  - Each output is an active-high reset released synchronously to its own clock.
- Parameter SYNC_STAGES, default 2: number of synchronizer flops per domain (legal ≥2); sets the release latency.
- clk_sys, input, 1: system clock (100 MHz nominal).
- pix_clk, input, 1: pixel clock (25 MHz nominal).
- ext_reset_n, input, 1: external reset button, active-low, asynchronous to both clocks.
- pll_locked, input, 1: PLL lock flag, active-high, asynchronous.
- srst, output, 1: system-domain reset, active-high.
- prst, output, 1: pixel-domain reset, active-high.

## Operation
- Global reset condition: arst = ~ext_reset_n | ~pll_locked.
- Each domain has one SYNC_STAGES-deep shift register.
  - Flops are asynchronously cleared by arst.
  - The first stage shifts in constant 1.
  - The output is the inverse of the last stage.
- While arst = 1, both outputs = 1 and all synchronizer flops = 0.
- Assertion is asynchronous: the output rises as soon as arst rises, with no clock edge needed. This still works when the PLL clocks are stopped.
- Release is synchronous: the output falls only on a rising edge of its own clock.
- Power-up and initial value of both outputs is 1.
- A new arst pulse during a pending release restarts the sequence from the beginning. Partial release never leaks through.
- Glitches on arst of any width, including sub-cycle, produce a full assertion followed by the full SYNC_STAGES release sequence.
- The two domains are independent. No ordering between srst and prst release is guaranteed beyond each one's own latency.

## Timing
- Let edge k be the first rising edge of a domain's clock at which arst is sampled 0 while it was 1 at edge k-1.
- With SYNC_STAGES = 2, the output samples as 1 at edges k and k+1, and as 0 at edge k+2.
- General case: the output is 1 for SYNC_STAGES sampled edges starting at k, then 0.
- The output never falls while ext_reset_n = 0 or pll_locked = 0.
- The output never falls in the same edge window in which arst deasserts.

## Configuration
- RESET_GEN_ASSERTIONS_EN defined: embedded SVA checks are compiled in, each firing $fatal on failure. The checks are:
  - no output release while arst = 1;
  - exact SYNC_STAGES-edge hold after arst release, per domain;
  - SYNC_STAGES ≥ 2 elaboration check.
- Macro undefined: no checks are compiled, and functional behaviour is identical.

## Structure
- Package reset_gen_pkg holds:
  - constant SYNC_STAGES_DEFAULT = 2;
  - the minimum legal stage count.
- Sub-module reset_sync (ports clk, arst, rst_out; parameter STAGES): a single-domain async-assert/sync-release synchronizer. reset_gen instantiates it twice, once on clk_sys and once on pix_clk.
- The arst OR-gate is combinational in reset_gen.
- Synchronizer flops carry ASYNC_REG / synthesis keep attributes.

## Test plan
- Power-up:
  - Stimulus: ext_reset_n = 0, pll_locked = 0 for 54 ns; clk_sys period 10 ns, pix_clk period 40 ns, both starting low at t = 0.
  - Required: srst = prst = 1 throughout.
- Release at 54 ns:
  - srst samples 1 at clk_sys edges 55 ns and 65 ns, and 0 from 75 ns.
  - prst samples 1 at pix_clk edges 60 ns and 100 ns, and 0 from 140 ns.
- ext_reset_n low pulse 254–294 ns:
  - Both outputs rise at 254 ns without waiting for a clock edge.
  - srst samples 0 from 315 ns.
  - prst samples 0 from 380 ns.
- pll_locked low pulse 394–434 ns: same response as the ext_reset_n pulse, with immediate assertion and a 2-edge hold per domain after 434 ns.
- Sub-cycle glitch (ext_reset_n low 3 ns between clk_sys edges):
  - Both outputs assert.
  - srst then holds 1 for 2 clk_sys edges.
  - prst then holds 1 for 2 pix_clk edges.
- Re-assert mid-release (arst returns to 1 one clk_sys edge after release):
  - srst stays 1 with no 0 sample.
  - The full 2-edge hold is measured from the final release.

Source files
------------

// File: rtl/reset_gen_pkg.sv
// Shared constants for the reset generator and its per-domain synchronizer.
// RESET_GEN_ASSERTIONS_EN (optional) compiles embedded SVA checks into reset_sync.
`timescale 1ns/1ps
package reset_gen_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int SYNC_STAGES_MIN     = 2;

endpackage

// File: rtl/reset_sync.sv
// Single-domain async-assert / sync-release reset synchronizer.
// RESET_GEN_ASSERTIONS_EN adds release-ordering and hold-length checks.
`timescale 1ns/1ps
module reset_sync
    import reset_gen_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic arst,
    output logic rst_out
);

    (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // A constant 1 walks in from stage 0; the reset releases once it reaches the last stage.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_out = ~sync_q[STAGES-1];

`ifdef RESET_GEN_ASSERTIONS_EN
    generate
        if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
            $fatal(1, "reset_sync: STAGES must be at least %0d", SYNC_STAGES_MIN);
        end
    endgenerate

    a_no_release_in_reset: assert property (@(posedge clk) arst |-> rst_out)
        else $fatal(1, "reset_sync: reset released while arst high");

    // Counted from the first edge that sees arst low after an edge that saw it high.
    a_exact_hold: assert property (@(posedge clk) disable iff (arst)
        (!arst && $past(arst)) |-> rst_out [*STAGES] ##1 !rst_out)
        else $fatal(1, "reset_sync: release hold length wrong");
`endif

endmodule

// File: rtl/reset_gen.sv
// Global reset generator: merges button reset and PLL lock, then releases
// one reset per clock domain (clk_sys, pix_clk). RESET_GEN_ASSERTIONS_EN enables SVA checks.
`timescale 1ns/1ps
module reset_gen
    import reset_gen_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk_sys,
    input  logic pix_clk,
    input  logic ext_reset_n,
    input  logic pll_locked,
    output logic srst,
    output logic prst
);

    logic arst;

    // Either source forces reset; stays combinational so assertion needs no clock.
    assign arst = ~ext_reset_n | ~pll_locked;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_sys (
        .clk     (clk_sys),
        .arst    (arst),
        .rst_out (srst)
    );

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_pix (
        .clk     (pix_clk),
        .arst    (arst),
        .rst_out (prst)
    );

endmodule

// File: tb/tb_reset_gen.sv
// Bench for reset_gen: timed directed checkpoints plus randomized pulses
// checked against an edge-counting reference model.
`timescale 1ns/1ps
module tb_reset_gen;

    localparam int SYNC_STAGES = 2;

    logic clk_sys;
    logic pix_clk;
    logic ext_reset_n;
    logic pll_locked;
    logic srst;
    logic prst;

    int checks = 0;
    int errors = 0;
    bit table_done = 0;

    reset_gen #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_sys     (clk_sys),
        .pix_clk     (pix_clk),
        .ext_reset_n (ext_reset_n),
        .pll_locked  (pll_locked),
        .srst        (srst),
        .prst        (prst)
    );

    // Clock/reset block: clk_sys rises at 5,15,..; pix_clk rises at 20,60,..
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        pix_clk = 1'b0;
        forever #20 pix_clk = ~pix_clk;
    end

    // Reference model: a domain stays in reset until it has seen SYNC_STAGES
    // rising edges in a row with the reset condition clear.
    wire arst_m = ~ext_reset_n | ~pll_locked;
    int s_clean = 0;
    int p_clean = 0;

    always @(posedge clk_sys or posedge arst_m) begin
        if (arst_m) s_clean = 0;
        else if (s_clean < 1000) s_clean = s_clean + 1;
    end

    always @(posedge pix_clk or posedge arst_m) begin
        if (arst_m) p_clean = 0;
        else if (p_clean < 1000) p_clean = p_clean + 1;
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Continuous model checks, sampled on the inactive clock edge.
    always @(negedge clk_sys) begin
        check_bit("srst_model", srst, (s_clean < SYNC_STAGES));
    end

    always @(negedge pix_clk) begin
        check_bit("prst_model", prst, (p_clean < SYNC_STAGES));
    end

    // Assertion must follow arst without waiting for any clock edge.
    always @(posedge arst_m) begin
        #1;
        check_bit("srst_async_assert", srst, 1'b1);
        check_bit("prst_async_assert", prst, 1'b1);
    end

    // Directed checkpoints: time and required outputs just before/after notable edges.
    typedef struct {
        int   t;
        logic s;
        logic p;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int now_t;
        vecs.push_back('{10,  1'b1, 1'b1});  // power-up, arst held
        vecs.push_back('{50,  1'b1, 1'b1});
        vecs.push_back('{59,  1'b1, 1'b1});  // one sys edge after release
        vecs.push_back('{64,  1'b1, 1'b1});  // sampled 1 at 65
        vecs.push_back('{74,  1'b0, 1'b1});  // srst 0 from 75
        vecs.push_back('{99,  1'b0, 1'b1});  // prst sampled 1 at 100
        vecs.push_back('{139, 1'b0, 1'b0});  // prst 0 from 140
        vecs.push_back('{250, 1'b0, 1'b0});
        vecs.push_back('{256, 1'b1, 1'b1});  // ext_reset_n pulse asserts
        vecs.push_back('{293, 1'b1, 1'b1});
        vecs.push_back('{304, 1'b1, 1'b1});
        vecs.push_back('{314, 1'b0, 1'b1});
        vecs.push_back('{339, 1'b0, 1'b1});
        vecs.push_back('{379, 1'b0, 1'b0});
        vecs.push_back('{396, 1'b1, 1'b1});  // pll_locked pulse asserts
        vecs.push_back('{444, 1'b1, 1'b1});
        vecs.push_back('{454, 1'b0, 1'b1});
        vecs.push_back('{499, 1'b0, 1'b1});
        vecs.push_back('{539, 1'b0, 1'b0});
        vecs.push_back('{603, 1'b1, 1'b1});  // 3 ns glitch
        vecs.push_back('{614, 1'b1, 1'b1});
        vecs.push_back('{624, 1'b0, 1'b1});
        vecs.push_back('{659, 1'b0, 1'b1});
        vecs.push_back('{699, 1'b0, 1'b0});
        vecs.push_back('{716, 1'b1, 1'b1});  // one sys edge into release
        vecs.push_back('{719, 1'b1, 1'b1});  // re-asserted
        vecs.push_back('{724, 1'b1, 1'b1});
        vecs.push_back('{734, 1'b1, 1'b1});  // hold restarted from 720
        vecs.push_back('{744, 1'b0, 1'b1});
        vecs.push_back('{779, 1'b0, 1'b1});
        vecs.push_back('{819, 1'b0, 1'b0});
        now_t = 0;
        foreach (vecs[i]) begin
            #(vecs[i].t - now_t);
            now_t = vecs[i].t;
            check_bit("srst_table", srst, vecs[i].s);
            check_bit("prst_table", prst, vecs[i].p);
        end
        table_done = 1'b1;
    end

    // Driver: pulse one reset source low for w ns, keeping edges of the
    // stimulus off every clock edge (times never a multiple of 5 ns).
    task automatic drive_pulse(input bit use_pll, input int w);
        if (use_pll) pll_locked = 1'b0;
        else ext_reset_n = 1'b0;
        #(w);
        if (use_pll) pll_locked = 1'b1;
        else ext_reset_n = 1'b1;
    endtask

    initial begin
        int w;
        int gap;
        ext_reset_n = 1'b0;
        pll_locked  = 1'b0;
        #54;                                   // t = 54
        ext_reset_n = 1'b1;
        pll_locked  = 1'b1;
        #200;  drive_pulse(1'b0, 40);          // 254..294
        #100;  drive_pulse(1'b1, 40);          // 394..434
        #167;  drive_pulse(1'b0, 3);           // 601..604
        #98;   drive_pulse(1'b0, 6);           // 702..708
        #10;   drive_pulse(1'b0, 2);           // 718..720
        #182;                                  // t = 902, 2 mod 5
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0: w = 2;
                1: w = 4;
                default: w = 5 * $urandom_range(1, 12);
            endcase
            drive_pulse($urandom_range(0, 1) == 1, w);
            gap = ((5 - (w % 5)) % 5) + 5 * $urandom_range(1, 30);
            #(gap);
        end
        #200;
        if (!table_done) begin
            check_bit("table_completed", table_done, 1'b1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
